// File: rtl/calc_key_sequencer.sv
// ---------------------------------------------------------------------------
// calc_key_sequencer
//  Front-end controller for the 4-digit BCD add/sub calculator datapath.
//  Turns decoded keypad events into the datapath control strobes
//  (is_num/num_val, is_op1/is_op2, op_val, save, mem_clr).
//
//  Optional feature macro: CALC_TIMEOUT_EN
//    When defined, an idle counter performs an automatic clear after
//    TIMEOUT_CYCLES cycles without an accepted key (not counted in S_SAVE).
//
//  Ports
//    clk        in   system clock, rising edge
//    rst        in   synchronous reset, active-high
//    key_valid  in   key event present, held until accepted
//    key_code   in   [3:0] digit 0-9, OP_ADD, OP_SUB, KEY_EQ, KEY_CLR
//    key_ready  out  a key can be accepted this cycle (low only in S_SAVE)
//    f_OF       in   datapath overflow flag
//    is_num     out  pulse: num_val holds a digit to store
//    num_val    out  [3:0] digit value
//    is_op1     out  level: digits go to operand 1
//    is_op2     out  level: digits go to operand 2
//    op_val     out  [3:0] selected operator
//    save       out  pulse: datapath latches result
//    mem_clr    out  pulse: clear datapath digit memories
//    key_err    out  pulse: key accepted but ignored
//    ovf_err    out  sticky overflow of the last result
//    digit_cnt  out  [2:0] digits entered into the current operand
// ---------------------------------------------------------------------------
module calc_key_sequencer #(
    parameter int unsigned MAX_DIGITS     = 4,
    parameter logic [3:0]  OP_ADD         = 4'hD,
    parameter logic [3:0]  OP_SUB         = 4'hC,
    parameter logic [3:0]  KEY_EQ         = 4'hE,
    parameter logic [3:0]  KEY_CLR        = 4'hF,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic       f_OF,
    output logic       is_num,
    output logic [3:0] num_val,
    output logic       is_op1,
    output logic       is_op2,
    output logic [3:0] op_val,
    output logic       save,
    output logic       mem_clr,
    output logic       key_err,
    output logic       ovf_err,
    output logic [2:0] digit_cnt
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned IDLE_W = 26;

    // Elaboration-time parameter sanity
    if (MAX_DIGITS < 1 || MAX_DIGITS > 4) begin : g_bad_max_digits
        $error("calc_key_sequencer: MAX_DIGITS must be 1..4");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (2 ** IDLE_W)) begin : g_bad_timeout
        $error("calc_key_sequencer: TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        S_OP1  = 2'd0,
        S_OP2  = 2'd1,
        S_SAVE = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    state_t state;

    logic accept;
    logic key_is_digit;
    logic key_is_op;
    logic key_is_clr;
    logic has_room;
    logic timeout_hit;
    logic clr_req;

    // Key classification for the accepted event
    assign accept       = key_valid & key_ready;
    assign key_is_digit = (key_code <= 4'd9);
    assign key_is_op    = (key_code == OP_ADD) || (key_code == OP_SUB);
    assign key_is_clr   = (key_code == KEY_CLR);
    assign has_room     = (digit_cnt < CNT_W'(MAX_DIGITS));

    // Key and timeout clears share one action, so a coincident pair gives one mem_clr.
    // S_SAVE never accepts keys and never times out, so a clear cannot abort a save.
    assign clr_req = (accept & key_is_clr) | timeout_hit;

`ifdef CALC_TIMEOUT_EN
    logic [IDLE_W-1:0] idle_cnt;

    assign timeout_hit = (state != S_SAVE) &&
                         (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Idle counter: restarts on any accepted key or auto-clear, frozen during save
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (accept || timeout_hit) begin
            idle_cnt <= '0;
        end else if (state != S_SAVE) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Sequencer FSM with registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_OP1;
            key_ready <= 1'b1;
            is_num    <= 1'b0;
            num_val   <= 4'd0;
            is_op1    <= 1'b1;
            is_op2    <= 1'b0;
            op_val    <= 4'd0;
            save      <= 1'b0;
            mem_clr   <= 1'b0;
            key_err   <= 1'b0;
            ovf_err   <= 1'b0;
            digit_cnt <= '0;
        end else begin
            is_num  <= 1'b0;
            save    <= 1'b0;
            mem_clr <= 1'b0;
            key_err <= 1'b0;

            if (clr_req) begin
                state     <= S_OP1;
                key_ready <= 1'b1;
                is_op1    <= 1'b1;
                is_op2    <= 1'b0;
                op_val    <= 4'd0;
                digit_cnt <= '0;
                ovf_err   <= 1'b0;
                mem_clr   <= 1'b1;
            end else begin
                case (state)
                    S_OP1, S_OP2: begin
                        if (accept) begin
                            if (key_is_digit) begin
                                // Saturate: extra digits are rejected, count never wraps
                                if (has_room) begin
                                    is_num    <= 1'b1;
                                    num_val   <= key_code;
                                    digit_cnt <= digit_cnt + CNT_W'(1);
                                end else begin
                                    key_err <= 1'b1;
                                end
                            end else if (key_is_op) begin
                                op_val <= key_code;
                                // Operator in operand 2 only replaces the operator
                                if (state == S_OP1) begin
                                    state     <= S_OP2;
                                    is_op1    <= 1'b0;
                                    is_op2    <= 1'b1;
                                    digit_cnt <= '0;
                                end
                            end else if ((key_code == KEY_EQ) && (state == S_OP2)) begin
                                state     <= S_SAVE;
                                save      <= 1'b1;
                                key_ready <= 1'b0;
                            end else begin
                                key_err <= 1'b1;
                            end
                        end
                    end

                    S_SAVE: begin
                        // Result is on the datapath while save is high; capture its overflow
                        ovf_err   <= f_OF;
                        state     <= S_SHOW;
                        is_op2    <= 1'b0;
                        key_ready <= 1'b1;
                    end

                    S_SHOW: begin
                        if (accept) begin
                            key_err <= 1'b1;
                        end
                    end

                    default: begin
                        state     <= S_OP1;
                        key_ready <= 1'b1;
                        is_op1    <= 1'b1;
                        is_op2    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
